tx_st_arbiter_gowin: RTL and testbench
======================================

// Module: tx_st_arbiter_gowin
// PURPOSE
//  Packet-atomic round-robin arbiter sharing the Gowin TX streaming port between two TX
//  Classic requesters (req0: completion engine, req1: read/write request engine).
//  Converts Classic framing (start/end flag, end offset) to Gowin SOP/EOP/EMPTY and
//  registers the output beat. Sits between the RIFFA TX engines and the Gowin PCIe TX core.
// PARAMETERS
//  C_PCI_DATA_WIDTH  256  datapath width in bits; only 256 is supported (8 DWs per beat)
//  C_REQ0_PRIORITY   0    1: req0 wins every tie; 0: round-robin ties
// PORTS
//  CLK                 in   1    clock; all logic rising-edge
//  RST_N               in   1    reset, asynchronous assert, active-low
//  TX0_TLP             in   256  req0 beat data, DW0 in bits [31:0]
//  TX0_TLP_VALID       in   1    req0 beat valid
//  TX0_TLP_START_FLAG  in   1    req0 first beat of TLP
//  TX0_TLP_END_FLAG    in   1    req0 last beat of TLP
//  TX0_TLP_END_OFFSET  in   3    req0 index of last valid DW in the end beat
//  TX0_TLP_READY       out  1    req0 beat accepted when VALID&READY
//  TX1_*               --   --   identical set for req1
//  TX_ST_DATA          out  256  beat to Gowin core
//  TX_ST_VALID         out  1    beat valid
//  TX_ST_READY         in   1    core accepts beat when VALID&READY
//  TX_ST_SOP           out  1    first beat of TLP
//  TX_ST_EOP           out  1    last beat of TLP
//  TX_ST_EMPTY         out  1    1 = upper 128 bits of EOP beat invalid (END_OFFSET<=3)
//  ERR_DROP            out  1    one-cycle pulse: non-SOP beat discarded while IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=req0, all outputs 0 (TX_ST_DATA=0, READYs=0, ERR_DROP=0).
//  States: IDLE, GNT0, GNT1 (registered grant).
//   IDLE: candidate n = TXn_VALID & TXn_START_FLAG. One candidate -> GNTn next cycle.
//    Both -> C_REQ0_PRIORITY ? GNT0 : requester named by rr pointer; rr := other one.
//    No TXn_READY in IDLE except for discard: TXn_VALID & !START_FLAG -> TXn_READY=1,
//    beat dropped, ERR_DROP=1 next cycle (both requesters may drop in the same cycle).
//   GNTn: TXn_READY = !TX_ST_VALID | TX_ST_READY (combinational); other requester READY=0.
//    Accepted beat with END_FLAG -> IDLE. START_FLAG mid-packet is forwarded as-is.
//  Output register load enable: accept = TXn_VALID & TXn_READY in GNTn. On accept:
//   DATA=TXn_TLP, SOP=START_FLAG, EOP=END_FLAG, EMPTY=END_FLAG & (END_OFFSET<=3), VALID=1.
//   Else if TX_ST_READY: VALID=0 (DATA/SOP/EOP/EMPTY hold). Else all hold (backpressure).
//  Latency: request->grant 1 cycle; accept->TX_ST_VALID 1 cycle. Sustained 1 beat/cycle
//   within a packet while TX_ST_READY=1; one bubble cycle between packets (IDLE visit).
//  Outputs stable while TX_ST_VALID=1 & TX_ST_READY=0; no beat lost or duplicated.
//  Packets never interleave: the non-granted requester waits however long the grant lasts.
//  Reset mid-packet: immediate abort, output beat lost, core-side recovery is upstream's.
// TESTING
//  1 req0 3-beat TLP, END_OFFSET=2, READY=1 -> SOP,-,EOP beats 1 cycle late, EMPTY=1 on EOP.
//  2 both VALID+START at reset exit, RR mode -> req0 packet first, then req1, then req0.
//  3 READY low 4 cycles mid-packet -> DATA/SOP/EOP stable, TXn_READY=0, no drop/duplicate.
//  4 req1 single beat START&END, END_OFFSET=7 -> SOP=EOP=1, EMPTY=0, back to IDLE.
//  5 req0 VALID w/o START in IDLE -> TX0_READY=1 that cycle, ERR_DROP pulse, TX_ST_VALID=0.
//  6 RST_N low during beat 2 of 4 -> all outputs 0 asynchronously, state IDLE, rr=req0.

Source files
------------

// File: rtl/tx_st_arbiter_gowin_if.sv
// Bundles the two TX Classic requester streams and the Gowin TX streaming port.
// slave = arbiter view, master = the engines/core environment around it.
interface tx_st_arbiter_gowin_if #(
   parameter int unsigned W = 256
);
   logic [W-1:0] tx0_tlp;
   logic         tx0_tlp_valid;
   logic         tx0_tlp_start_flag;
   logic         tx0_tlp_end_flag;
   logic [2:0]   tx0_tlp_end_offset;
   logic         tx0_tlp_ready;

   logic [W-1:0] tx1_tlp;
   logic         tx1_tlp_valid;
   logic         tx1_tlp_start_flag;
   logic         tx1_tlp_end_flag;
   logic [2:0]   tx1_tlp_end_offset;
   logic         tx1_tlp_ready;

   logic [W-1:0] tx_st_data;
   logic         tx_st_valid;
   logic         tx_st_ready;
   logic         tx_st_sop;
   logic         tx_st_eop;
   logic         tx_st_empty;

   modport slave (
      input  tx0_tlp, tx0_tlp_valid, tx0_tlp_start_flag, tx0_tlp_end_flag, tx0_tlp_end_offset,
      output tx0_tlp_ready,
      input  tx1_tlp, tx1_tlp_valid, tx1_tlp_start_flag, tx1_tlp_end_flag, tx1_tlp_end_offset,
      output tx1_tlp_ready,
      output tx_st_data, tx_st_valid, tx_st_sop, tx_st_eop, tx_st_empty,
      input  tx_st_ready
   );

   modport master (
      output tx0_tlp, tx0_tlp_valid, tx0_tlp_start_flag, tx0_tlp_end_flag, tx0_tlp_end_offset,
      input  tx0_tlp_ready,
      output tx1_tlp, tx1_tlp_valid, tx1_tlp_start_flag, tx1_tlp_end_flag, tx1_tlp_end_offset,
      input  tx1_tlp_ready,
      input  tx_st_data, tx_st_valid, tx_st_sop, tx_st_eop, tx_st_empty,
      output tx_st_ready
   );
endinterface

// File: rtl/tx_st_arbiter_gowin.sv
// Packet-atomic round-robin arbiter of two TX Classic requesters onto the Gowin TX
// streaming port, with Classic->SOP/EOP/EMPTY conversion and a registered output beat.
module tx_st_arbiter_gowin #(
   parameter int unsigned C_PCI_DATA_WIDTH = 256,
   parameter bit          C_REQ0_PRIORITY  = 1'b0
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   tx_st_arbiter_gowin_if.slave   if_tx,
   output logic                   o_err_drop
);
   localparam int unsigned DW = C_PCI_DATA_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GNT0 = 2'd1,
      S_GNT1 = 2'd2
   } state_t;

   state_t        r_state;
   logic          r_rr;       // 0: req0 wins the next tie, 1: req1 wins
   logic [DW-1:0] r_data;
   logic          r_valid;
   logic          r_sop;
   logic          r_eop;
   logic          r_empty;
   logic          r_err_drop;

   logic          w_idle;
   logic          w_cand0;
   logic          w_cand1;
   logic          w_drop0;
   logic          w_drop1;
   logic          w_out_free;
   logic          w_acc0;
   logic          w_acc1;
   logic          w_acc;
   logic [DW-1:0] w_acc_data;
   logic          w_acc_sop;
   logic          w_acc_eop;
   logic [2:0]    w_acc_off;

   assign w_idle     = (r_state == S_IDLE);
   assign w_cand0    = if_tx.tx0_tlp_valid & if_tx.tx0_tlp_start_flag;
   assign w_cand1    = if_tx.tx1_tlp_valid & if_tx.tx1_tlp_start_flag;
   assign w_drop0    = w_idle & if_tx.tx0_tlp_valid & ~if_tx.tx0_tlp_start_flag;
   assign w_drop1    = w_idle & if_tx.tx1_tlp_valid & ~if_tx.tx1_tlp_start_flag;
   assign w_out_free = ~r_valid | if_tx.tx_st_ready;

   assign w_acc0 = (r_state == S_GNT0) & if_tx.tx0_tlp_valid & w_out_free;
   assign w_acc1 = (r_state == S_GNT1) & if_tx.tx1_tlp_valid & w_out_free;
   assign w_acc  = w_acc0 | w_acc1;

   // Discard-ready is gated by reset so every output reads 0 while reset is held
   assign if_tx.tx0_tlp_ready = ((r_state == S_GNT0) & w_out_free) | (w_drop0 & i_rst_n);
   assign if_tx.tx1_tlp_ready = ((r_state == S_GNT1) & w_out_free) | (w_drop1 & i_rst_n);

   assign w_acc_data = (r_state == S_GNT1) ? if_tx.tx1_tlp            : if_tx.tx0_tlp;
   assign w_acc_sop  = (r_state == S_GNT1) ? if_tx.tx1_tlp_start_flag : if_tx.tx0_tlp_start_flag;
   assign w_acc_eop  = (r_state == S_GNT1) ? if_tx.tx1_tlp_end_flag   : if_tx.tx0_tlp_end_flag;
   assign w_acc_off  = (r_state == S_GNT1) ? if_tx.tx1_tlp_end_offset : if_tx.tx0_tlp_end_offset;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_rr       <= 1'b0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_sop      <= 1'b0;
         r_eop      <= 1'b0;
         r_empty    <= 1'b0;
         r_err_drop <= 1'b0;
      end else begin
         r_err_drop <= w_drop0 | w_drop1;

         case (r_state)
            S_IDLE: begin
               if (w_cand0 & w_cand1) begin
                  if (C_REQ0_PRIORITY | ~r_rr) begin
                     r_state <= S_GNT0;
                     r_rr    <= 1'b1;
                  end else begin
                     r_state <= S_GNT1;
                     r_rr    <= 1'b0;
                  end
               end else if (w_cand0) begin
                  r_state <= S_GNT0;
               end else if (w_cand1) begin
                  r_state <= S_GNT1;
               end
            end
            S_GNT0:  if (w_acc0 & if_tx.tx0_tlp_end_flag) r_state <= S_IDLE;
            S_GNT1:  if (w_acc1 & if_tx.tx1_tlp_end_flag) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase

         // Output beat: load on accept, retire on core ready, otherwise hold
         if (w_acc) begin
            r_data  <= w_acc_data;
            r_sop   <= w_acc_sop;
            r_eop   <= w_acc_eop;
            r_empty <= w_acc_eop & ~w_acc_off[2];
            r_valid <= 1'b1;
         end else if (if_tx.tx_st_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign if_tx.tx_st_data  = r_data;
   assign if_tx.tx_st_valid = r_valid;
   assign if_tx.tx_st_sop   = r_sop;
   assign if_tx.tx_st_eop   = r_eop;
   assign if_tx.tx_st_empty = r_empty;
   assign o_err_drop        = r_err_drop;
endmodule

// File: tb/tb_tx_st_arbiter_gowin.sv
// Bench for tx_st_arbiter_gowin: directed scenarios plus randomized traffic scored
// against a packet-level model (beat queues, open-packet owner, drop rule).
module tb_tx_st_arbiter_gowin;
   localparam int unsigned W = 256;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic err_drop;
   always #5 clk = ~clk;

   tx_st_arbiter_gowin_if #(.W(W)) bus ();

   tx_st_arbiter_gowin #(.C_PCI_DATA_WIDTH(W), .C_REQ0_PRIORITY(1'b0)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .if_tx      (bus),
      .o_err_drop (err_drop)
   );

   typedef struct {
      logic [W-1:0] d;
      logic         s;
      logic         e;
      logic [2:0]   off;
   } beat_t;

   typedef struct {
      logic [W-1:0] d;
      logic         sop;
      logic         eop;
      logic         emp;
   } exp_t;

   beat_t q0[$];
   beat_t q1[$];
   exp_t  exp_q[$];
   int    sop_src[$];

   int n_tests = 0;
   int n_fail  = 0;

   int v_pct = 100, rdy_pct = 100, stall_lo = -1, stall_hi = -1;
   int lc = 0;
   int open_src = -1;
   logic exp_drop = 1'b0;
   logic p_acc = 1'b0;
   logic [W-1:0] p_d;
   logic p_stall = 1'b0;
   logic [W-1:0] s_d;
   logic [3:0] s_ctl;
   logic log_v[64], log_sop[64], log_eop[64], log_emp[64], log_r0[64], log_r1[64], log_drop[64];

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, want);
      end
   endtask

   function automatic logic [W-1:0] rnd();
      logic [W-1:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic add_pkt(input int n, input int len, input logic [2:0] off);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.d   = rnd();
         b.s   = (i == 0);
         b.e   = (i == len - 1);
         b.off = (i == len - 1) ? off : 3'($urandom_range(7));
         if (n == 0) q0.push_back(b); else q1.push_back(b);
      end
   endtask

   task automatic drive();
      beat_t b;
      bus.tx_st_ready = (lc >= stall_lo && lc <= stall_hi) ? 1'b0
                                                          : 1'($urandom_range(99) < rdy_pct);
      if (q0.size() > 0 && $urandom_range(99) < v_pct) begin
         b = q0[0];
         bus.tx0_tlp = b.d; bus.tx0_tlp_valid = 1'b1; bus.tx0_tlp_start_flag = b.s;
         bus.tx0_tlp_end_flag = b.e; bus.tx0_tlp_end_offset = b.off;
      end else begin
         bus.tx0_tlp = '0; bus.tx0_tlp_valid = 1'b0; bus.tx0_tlp_start_flag = 1'b0;
         bus.tx0_tlp_end_flag = 1'b0; bus.tx0_tlp_end_offset = 3'd0;
      end
      if (q1.size() > 0 && $urandom_range(99) < v_pct) begin
         b = q1[0];
         bus.tx1_tlp = b.d; bus.tx1_tlp_valid = 1'b1; bus.tx1_tlp_start_flag = b.s;
         bus.tx1_tlp_end_flag = b.e; bus.tx1_tlp_end_offset = b.off;
      end else begin
         bus.tx1_tlp = '0; bus.tx1_tlp_valid = 1'b0; bus.tx1_tlp_start_flag = 1'b0;
         bus.tx1_tlp_end_flag = 1'b0; bus.tx1_tlp_end_offset = 3'd0;
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      sop_src.delete();
      open_src = -1;
      exp_drop = 1'b0;
      p_acc    = 1'b0;
      p_stall  = 1'b0;
   endtask

   // Sampled on the falling edge: score outputs, then account for this cycle's accepts
   task automatic mon();
      logic  acc[2];
      beat_t b;
      exp_t  e;
      acc[0] = bus.tx0_tlp_valid & bus.tx0_tlp_ready;
      acc[1] = bus.tx1_tlp_valid & bus.tx1_tlp_ready;
      if (p_acc) begin
         check("lat_valid", W'(bus.tx_st_valid), W'(1'b1));
         check("lat_data", bus.tx_st_data, p_d);
      end
      if (p_stall) begin
         check("hold_data", bus.tx_st_data, s_d);
         check("hold_ctl", W'({bus.tx_st_valid, bus.tx_st_sop, bus.tx_st_eop, bus.tx_st_empty}), W'(s_ctl));
      end
      check("err_drop", W'(err_drop), W'(exp_drop));
      if (bus.tx_st_valid && bus.tx_st_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_beat", W'(bus.tx_st_valid), W'(1'b0));
         end else begin
            e = exp_q.pop_front();
            check("beat_data", bus.tx_st_data, e.d);
            check("beat_ctl", W'({bus.tx_st_sop, bus.tx_st_eop, bus.tx_st_empty}), W'({e.sop, e.eop, e.emp}));
         end
      end
      exp_drop = 1'b0;
      p_acc    = 1'b0;
      for (int n = 0; n < 2; n++) begin
         if (acc[n]) begin
            b = (n == 0) ? q0.pop_front() : q1.pop_front();
            if (open_src < 0 && !b.s) begin
               exp_drop = 1'b1;
            end else begin
               if (open_src >= 0) check("atomic_src", W'(n), W'(open_src));
               if (b.s) sop_src.push_back(n);
               e.d = b.d; e.sop = b.s; e.eop = b.e; e.emp = b.e && (b.off <= 3'd3);
               exp_q.push_back(e);
               open_src = b.e ? -1 : n;
               p_acc = 1'b1;
               p_d   = b.d;
            end
         end
      end
      p_stall = bus.tx_st_valid & ~bus.tx_st_ready;
      s_d     = bus.tx_st_data;
      s_ctl   = {bus.tx_st_valid, bus.tx_st_sop, bus.tx_st_eop, bus.tx_st_empty};
      if (lc < 64) begin
         log_v[lc] = bus.tx_st_valid;  log_sop[lc] = bus.tx_st_sop; log_eop[lc] = bus.tx_st_eop;
         log_emp[lc] = bus.tx_st_empty; log_r0[lc] = bus.tx0_tlp_ready;
         log_r1[lc] = bus.tx1_tlp_ready; log_drop[lc] = err_drop;
      end
      lc++;
   endtask

   task automatic run(input int cycles);
      repeat (cycles) begin
         drive();
         @(negedge clk);
         mon();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_reset();
      lc = 0;
      stall_lo = -1; stall_hi = -1;
      drive();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      lc = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      v_pct = 100; rdy_pct = 100;
      bus.tx_st_ready = 1'b0;
      drive();
      #2;
      check("rst_valid", W'(bus.tx_st_valid), W'(1'b0));
      check("rst_data", bus.tx_st_data, '0);
      check("rst_ready", W'({bus.tx0_tlp_ready, bus.tx1_tlp_ready, err_drop}), W'(3'b000));

      // 3-beat req0 packet, END_OFFSET=2
      apply_reset();
      add_pkt(0, 3, 3'd2);
      run(8);
      check("t1_valid_seq", W'({log_v[0], log_v[1], log_v[2], log_v[3], log_v[4], log_v[5]}), W'(6'b001110));
      check("t1_sop", W'({log_sop[2], log_eop[2]}), W'(2'b10));
      check("t1_eop_empty", W'({log_sop[4], log_eop[4], log_emp[4]}), W'(3'b011));
      check("t1_ready", W'({log_r0[0], log_r0[1]}), W'(2'b01));
      check("t1_drain", W'(exp_q.size()), W'(0));

      // Tie at reset exit in round-robin mode
      q0.delete(); q1.delete();
      add_pkt(0, 2, 3'd7); add_pkt(1, 2, 3'd1); add_pkt(0, 2, 3'd4);
      apply_reset();
      run(20);
      check("t2_npkts", W'(sop_src.size()), W'(3));
      if (sop_src.size() == 3)
         check("t2_order", W'({sop_src[0][1:0], sop_src[1][1:0], sop_src[2][1:0]}), W'(6'b000100));
      check("t2_drain", W'(exp_q.size() + q0.size() + q1.size()), W'(0));

      // Core backpressure for 4 cycles mid-packet
      apply_reset();
      add_pkt(0, 4, 3'd5);
      stall_lo = 3; stall_hi = 6;
      run(14);
      for (int i = 3; i <= 6; i++) check("t3_stall", W'({log_v[i], log_r0[i]}), W'(2'b10));
      check("t3_drain", W'(exp_q.size() + q0.size()), W'(0));

      // req1 single-beat packets, END_OFFSET=7 then 0
      apply_reset();
      add_pkt(1, 1, 3'd7); add_pkt(1, 1, 3'd0);
      run(8);
      check("t4_single", W'({log_v[2], log_sop[2], log_eop[2], log_emp[2]}), W'(4'b1110));
      check("t4_idle_again", W'({log_r1[0], log_r1[1], log_r1[2], log_r1[3]}), W'(4'b0101));
      check("t4_empty_hi", W'(log_emp[4]), W'(1'b1));

      // Non-SOP beats in IDLE from both requesters are discarded
      apply_reset();
      begin
         beat_t b;
         b.d = rnd(); b.s = 1'b0; b.e = 1'b1; b.off = 3'd3; q0.push_back(b);
         b.d = rnd(); b.s = 1'b0; b.e = 1'b0; b.off = 3'd6; q1.push_back(b);
      end
      run(4);
      check("t5_drop_ready", W'({log_r0[0], log_r1[0]}), W'(2'b11));
      check("t5_pulse", W'({log_drop[1], log_drop[2], log_v[1]}), W'(3'b100));

      // Reset during beat 2 of 4 after req0 won a tie; rr must return to req0
      apply_reset();
      add_pkt(0, 4, 3'd1); add_pkt(1, 1, 3'd1);
      run(3);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_ctl", W'({bus.tx_st_valid, bus.tx_st_sop, bus.tx_st_eop, bus.tx_st_empty}), W'(4'b0000));
      check("t6_async_data", bus.tx_st_data, '0);
      check("t6_async_ready", W'({bus.tx0_tlp_ready, bus.tx1_tlp_ready, err_drop}), W'(3'b000));
      q0.delete(); q1.delete();
      add_pkt(0, 1, 3'd2); add_pkt(1, 1, 3'd2);
      apply_reset();
      run(8);
      check("t6_npkts", W'(sop_src.size()), W'(2));
      if (sop_src.size() == 2) check("t6_rr_reset", W'({sop_src[0][0], sop_src[1][0]}), W'(2'b01));

      // Randomized traffic against the packet-level model
      q0.delete(); q1.delete();
      apply_reset();
      for (int i = 0; i < 40; i++) begin
         add_pkt(0, int'($urandom_range(1, 4)), 3'($urandom_range(7)));
         add_pkt(1, int'($urandom_range(1, 4)), 3'($urandom_range(7)));
      end
      v_pct = 75; rdy_pct = 70;
      cyc = 0;
      while ((q0.size() > 0 || q1.size() > 0) && cyc < 4000) begin
         run(1);
         cyc++;
      end
      v_pct = 100; rdy_pct = 100;
      run(5);
      check("rand_inputs_done", W'(q0.size() + q1.size()), W'(0));
      check("rand_outputs_done", W'(exp_q.size()), W'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
